bpu_update_ctrl: RTL and testbench
==================================

BPU_UPDATE_CTRL -- requirements
Module: bpu_update_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, 4, number of update-queue entries; must be a power of two and at least 2.
REQ-002 SHALL have parameter DEPTH_W, 2, log2(DEPTH).
REQ-003 SHALL have port clk_i  input  1  single clock; all state is updated on the rising edge.
REQ-004 SHALL have port rstn_i  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port br0_valid_i / br1_valid_i  input  1  resolved branch present on port 0 / port 1; in the same cycle, port 0 is older.
REQ-006 SHALL have ports brN_mispred_i, brN_taken_i, brN_is_call_i, brN_is_ret_i, brN_is_jmp_i  input  1 each  resolution info per port N (0 and 1).
REQ-007 SHALL have ports brN_source_i, brN_target_i  input  32 each  branch PC and resolved target per port N.
REQ-008 SHALL have port br_ready_o  output  1  queue can accept two entries this cycle.
REQ-009 SHALL have port stall_i  input  1  pause draining of the queue.
REQ-010 SHALL have port flush_i  input  1  discard all queued entries.
REQ-011 SHALL have port branch_request_o  output  1  drained entry was a mispredict.
REQ-012 SHALL have ports branch_is_taken_o, branch_is_not_taken_o  output  1 each  direction of the drained entry.
REQ-013 SHALL have ports branch_is_call_o, branch_is_ret_o, branch_is_jmp_o  output  1 each  type of the drained entry.
REQ-014 SHALL have ports branch_source_o, branch_pc_o  output  32 each  source PC and target of the drained entry.
REQ-015 SHALL have port q_count_o  output  DEPTH_W+1  current occupancy.
REQ-016 SHALL have port mispred_cnt_o  output  16  saturating count of drained mispredicts.
REQ-017 SHALL have port overflow_o  output  1  sticky: a valid push was dropped.

Function
REQ-018 SHALL store entries in a circular FIFO with DEPTH_W-bit read/write pointers that wrap modulo DEPTH, plus a DEPTH_W+1-bit count register.
REQ-019 SHALL drive br_ready_o = (DEPTH - count) >= 2, decoded from the registered count only.
REQ-020 SHALL push, when br_ready_o=1, port 0 first, then port 1 at the next slot; port 1 alone occupies one slot.
REQ-021 SHALL, when br_ready_o=0, drop any valid input and set overflow_o on the next edge; overflow_o stays set until reset.
REQ-022 SHALL define drain_en = (count != 0) & ~stall_i & ~flush_i.
REQ-023 SHALL drive all branch_* outputs combinationally from the head entry, qualified by drain_en.
REQ-024 SHALL pop exactly one entry on each edge where drain_en=1.
REQ-025 SHALL hold every branch_* output at 0 when drain_en=0.
REQ-026 SHALL set branch_is_taken_o = head.taken and branch_is_not_taken_o = ~head.taken, both qualified by drain_en; the two are never 1 together.
REQ-027 SHALL give a latency of 1: an entry pushed at edge N can appear at the outputs in the cycle after edge N, with no same-cycle bypass.
REQ-028 SHALL update count as count + pushes - pop when push and pop occur in the same cycle; occupancy never exceeds DEPTH.
REQ-029 SHALL preserve program order: drain order equals push order, with port 0 before port 1.
REQ-030 SHALL, on flush_i=1, zero the pointers and count at the next edge, drop that cycle's pushes, and produce no drain that cycle.
REQ-031 SHALL give flush_i priority over stall_i and over pushes.
REQ-032 SHALL still accept pushes when stall_i=1.
REQ-033 SHALL increment mispred_cnt_o on each drained entry with mispred=1, holding at 16'hFFFF; flush does not clear it.
REQ-034 SHALL drive q_count_o equal to the registered count.

Reset
REQ-035 SHALL, while rstn_i=0, asynchronously clear the pointers, count, mispred_cnt_o and overflow_o.
REQ-036 SHALL, while rstn_i=0, hold all branch_* outputs at 0 and br_ready_o at 1; entry payload is not reset.
REQ-037 SHALL, on reset asserted mid-operation, abandon all queued entries; the first push after release lands at slot 0.

Verification
REQ-038 Single push: port 0 pushes source=0x100, target=0x200, taken=1, mispred=1 -> next cycle branch_request_o=1, branch_is_taken_o=1, branch_source_o=0x100, branch_pc_o=0x200; mispred_cnt_o=1 after that cycle's edge.
REQ-039 Dual push ordering: in one cycle, port 0 source=0x10 and port 1 source=0x14 -> 0x10 drained, then 0x14 on consecutive cycles; q_count_o goes 2, 1, 0.
REQ-040 Full and overflow: with stall_i=1, push two pairs -> q_count_o=4 and br_ready_o=0; one more push -> overflow_o=1 and q_count_o stays 4; release stall -> four drains, then br_ready_o=1.
REQ-041 Wrap and simultaneous push/pop: run 10 cycles of one push plus one pop per cycle -> q_count_o constant and data in order across pointer wrap.
REQ-042 Flush: queue holds 3 entries, assert flush_i with a port 0 push -> q_count_o=0 next cycle, no branch_* output asserted, the pushed entry is never drained.
REQ-043 Saturation and reset: force 65536 mispredict drains -> mispred_cnt_o=0xFFFF; assert rstn_i mid-drain -> all outputs 0 immediately and q_count_o=0.

Source files
------------

// File: rtl/bpu_update_ctrl.sv
// Branch predictor update queue: collects up to two resolved branches per
// cycle and drains one per cycle, in program order, towards the predictor.
module bpu_update_ctrl #(
    parameter int DEPTH   = 4,
    parameter int DEPTH_W = 2
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,

    input  logic                 br0_valid_i,
    input  logic                 br0_mispred_i,
    input  logic                 br0_taken_i,
    input  logic                 br0_is_call_i,
    input  logic                 br0_is_ret_i,
    input  logic                 br0_is_jmp_i,
    input  logic [31:0]          br0_source_i,
    input  logic [31:0]          br0_target_i,

    input  logic                 br1_valid_i,
    input  logic                 br1_mispred_i,
    input  logic                 br1_taken_i,
    input  logic                 br1_is_call_i,
    input  logic                 br1_is_ret_i,
    input  logic                 br1_is_jmp_i,
    input  logic [31:0]          br1_source_i,
    input  logic [31:0]          br1_target_i,

    output logic                 br_ready_o,
    input  logic                 stall_i,
    input  logic                 flush_i,

    output logic                 branch_request_o,
    output logic                 branch_is_taken_o,
    output logic                 branch_is_not_taken_o,
    output logic                 branch_is_call_o,
    output logic                 branch_is_ret_o,
    output logic                 branch_is_jmp_o,
    output logic [31:0]          branch_source_o,
    output logic [31:0]          branch_pc_o,

    output logic [DEPTH_W:0]     q_count_o,
    output logic [15:0]          mispred_cnt_o,
    output logic                 overflow_o
);

    typedef struct packed {
        logic        mispred;
        logic        taken;
        logic        is_call;
        logic        is_ret;
        logic        is_jmp;
        logic [31:0] source;
        logic [31:0] target;
    } entry_t;

    localparam int CW = DEPTH_W + 1;
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

    entry_t             mem [DEPTH];
    entry_t             in0;
    entry_t             in1;
    entry_t             head;
    logic [DEPTH_W-1:0] rd_ptr;
    logic [DEPTH_W-1:0] wr_ptr;
    logic [DEPTH_W-1:0] wr_ptr1;
    logic [CW-1:0]      count;
    logic [CW-1:0]      count_nxt;
    logic               push0;
    logic               push1;
    logic               drain_en;
    logic               any_valid;

    assign in0 = {br0_mispred_i, br0_taken_i, br0_is_call_i,
                  br0_is_ret_i, br0_is_jmp_i,
                  br0_source_i, br0_target_i};
    assign in1 = {br1_mispred_i, br1_taken_i, br1_is_call_i,
                  br1_is_ret_i, br1_is_jmp_i,
                  br1_source_i, br1_target_i};

    // Room for a full pair is required even when only one port is valid.
    assign br_ready_o = (count <= READY_MAX);
    assign any_valid  = br0_valid_i | br1_valid_i;
    assign push0      = br0_valid_i & br_ready_o & ~flush_i;
    assign push1      = br1_valid_i & br_ready_o & ~flush_i;
    assign wr_ptr1    = wr_ptr + DEPTH_W'(push0);

    assign drain_en  = (count != '0) & ~stall_i & ~flush_i;
    assign head      = mem[rd_ptr];
    assign count_nxt = count + CW'(push0) + CW'(push1) - CW'(drain_en);

    assign branch_request_o      = drain_en & head.mispred;
    assign branch_is_taken_o     = drain_en & head.taken;
    assign branch_is_not_taken_o = drain_en & ~head.taken;
    assign branch_is_call_o      = drain_en & head.is_call;
    assign branch_is_ret_o       = drain_en & head.is_ret;
    assign branch_is_jmp_o       = drain_en & head.is_jmp;
    assign branch_source_o       = head.source & {32{drain_en}};
    assign branch_pc_o           = head.target & {32{drain_en}};

    assign q_count_o = count;

    // Payload needs no reset: count gates every read of it.
    always_ff @(posedge clk_i) begin
        if (push0) mem[wr_ptr]  <= in0;
        if (push1) mem[wr_ptr1] <= in1;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            mispred_cnt_o <= '0;
            overflow_o    <= 1'b0;
        end else begin
            if (any_valid & ~br_ready_o) overflow_o <= 1'b1;
            if (flush_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                rd_ptr <= rd_ptr + DEPTH_W'(drain_en);
                wr_ptr <= wr_ptr + DEPTH_W'(push0) + DEPTH_W'(push1);
                count  <= count_nxt;
            end
            if (drain_en & head.mispred & (mispred_cnt_o != 16'hFFFF))
                mispred_cnt_o <= mispred_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_bpu_update_ctrl.sv
// Scoreboard bench for bpu_update_ctrl: stimulus queues expected drains,
// a negedge monitor pops and compares every entry the DUT presents.
module tb_bpu_update_ctrl;

    typedef struct packed {
        logic        mispred;
        logic        taken;
        logic        is_call;
        logic        is_ret;
        logic        is_jmp;
        logic [31:0] source;
        logic [31:0] target;
    } ent_t;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        br0_valid_i, br0_mispred_i, br0_taken_i;
    logic        br0_is_call_i, br0_is_ret_i, br0_is_jmp_i;
    logic [31:0] br0_source_i, br0_target_i;
    logic        br1_valid_i, br1_mispred_i, br1_taken_i;
    logic        br1_is_call_i, br1_is_ret_i, br1_is_jmp_i;
    logic [31:0] br1_source_i, br1_target_i;
    logic        br_ready_o, stall_i, flush_i;
    logic        branch_request_o, branch_is_taken_o, branch_is_not_taken_o;
    logic        branch_is_call_o, branch_is_ret_o, branch_is_jmp_o;
    logic [31:0] branch_source_o, branch_pc_o;
    logic [2:0]  q_count_o;
    logic [15:0] mispred_cnt_o;
    logic        overflow_o;

    int   total = 0;
    int   bad   = 0;
    ent_t exp_q[$];

    bpu_update_ctrl #(.DEPTH(4), .DEPTH_W(2)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .br0_valid_i(br0_valid_i), .br0_mispred_i(br0_mispred_i),
        .br0_taken_i(br0_taken_i), .br0_is_call_i(br0_is_call_i),
        .br0_is_ret_i(br0_is_ret_i), .br0_is_jmp_i(br0_is_jmp_i),
        .br0_source_i(br0_source_i), .br0_target_i(br0_target_i),
        .br1_valid_i(br1_valid_i), .br1_mispred_i(br1_mispred_i),
        .br1_taken_i(br1_taken_i), .br1_is_call_i(br1_is_call_i),
        .br1_is_ret_i(br1_is_ret_i), .br1_is_jmp_i(br1_is_jmp_i),
        .br1_source_i(br1_source_i), .br1_target_i(br1_target_i),
        .br_ready_o(br_ready_o), .stall_i(stall_i), .flush_i(flush_i),
        .branch_request_o(branch_request_o),
        .branch_is_taken_o(branch_is_taken_o),
        .branch_is_not_taken_o(branch_is_not_taken_o),
        .branch_is_call_o(branch_is_call_o),
        .branch_is_ret_o(branch_is_ret_o),
        .branch_is_jmp_o(branch_is_jmp_o),
        .branch_source_o(branch_source_o), .branch_pc_o(branch_pc_o),
        .q_count_o(q_count_o), .mispred_cnt_o(mispred_cnt_o),
        .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic ent_t mk(logic mp, logic tk, logic c, logic r,
                                logic j, logic [31:0] s, logic [31:0] t);
        return {mp, tk, c, r, j, s, t};
    endfunction

    task automatic clr();
        br0_valid_i = 1'b0;
        br1_valid_i = 1'b0;
    endtask

    task automatic drv(int port, ent_t e);
        if (port == 0) begin
            br0_valid_i = 1'b1;
            {br0_mispred_i, br0_taken_i, br0_is_call_i, br0_is_ret_i,
             br0_is_jmp_i, br0_source_i, br0_target_i} = e;
        end else begin
            br1_valid_i = 1'b1;
            {br1_mispred_i, br1_taken_i, br1_is_call_i, br1_is_ret_i,
             br1_is_jmp_i, br1_source_i, br1_target_i} = e;
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, want);
        end
    endtask

    function automatic logic [31:0] outs_or();
        return {26'd0, branch_request_o, branch_is_taken_o,
                branch_is_not_taken_o, branch_is_call_o,
                branch_is_ret_o, branch_is_jmp_o}
               | branch_source_o | branch_pc_o;
    endfunction

    task automatic wait_drain(string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d entries left, want 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every presented entry must match the oldest expected one.
    ent_t        me;
    logic [69:0] got_v, want_v;
    always @(negedge clk_i) begin
        if (rstn_i && (branch_is_taken_o || branch_is_not_taken_o)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL drain_unexp: got src=%0h want none",
                         branch_source_o);
            end else begin
                me = exp_q.pop_front();
                got_v = {branch_request_o, branch_is_taken_o,
                         branch_is_not_taken_o, branch_is_call_o,
                         branch_is_ret_o, branch_is_jmp_o,
                         branch_source_o, branch_pc_o};
                want_v = {me.mispred, me.taken, ~me.taken, me.is_call,
                          me.is_ret, me.is_jmp, me.source, me.target};
                if (got_v !== want_v) begin
                    bad++;
                    $display("FAIL drain_data: got=%0h want=%0h",
                             got_v, want_v);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ent_t e;
        rstn_i = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        drv(0, '0);
        drv(1, '0);
        clr();
        #2;
        chk("rst_ready", 32'(br_ready_o), 1);
        chk("rst_count", 32'(q_count_o), 0);
        chk("rst_outs", outs_or(), 0);
        chk("rst_mp", 32'(mispred_cnt_o), 0);
        chk("rst_ovf", 32'(overflow_o), 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        step();

        // Single push
        e = mk(1, 1, 0, 0, 0, 32'h100, 32'h200);
        drv(0, e); exp_q.push_back(e);
        step(); clr();
        @(negedge clk_i);
        chk("single_count", 32'(q_count_o), 1);
        step();
        @(negedge clk_i);
        chk("single_mp", 32'(mispred_cnt_o), 1);
        chk("single_empty", 32'(q_count_o), 0);

        // Dual push ordering
        e = mk(0, 0, 0, 0, 1, 32'h10, 32'h50);
        drv(0, e); exp_q.push_back(e);
        e = mk(0, 1, 1, 0, 0, 32'h14, 32'h54);
        drv(1, e); exp_q.push_back(e);
        step(); clr();
        @(negedge clk_i);
        chk("dual_cnt2", 32'(q_count_o), 2);
        step();
        @(negedge clk_i);
        chk("dual_cnt1", 32'(q_count_o), 1);
        step();
        @(negedge clk_i);
        chk("dual_cnt0", 32'(q_count_o), 0);

        // Full and overflow under stall
        stall_i = 1'b1;
        e = mk(1, 1, 0, 1, 0, 32'h20, 32'h60);
        drv(0, e); exp_q.push_back(e);
        e = mk(0, 0, 0, 0, 0, 32'h24, 32'h64);
        drv(1, e); exp_q.push_back(e);
        step();
        e = mk(1, 0, 1, 0, 0, 32'h28, 32'h68);
        drv(0, e); exp_q.push_back(e);
        e = mk(0, 1, 0, 0, 1, 32'h2C, 32'h6C);
        drv(1, e); exp_q.push_back(e);
        step(); clr();
        @(negedge clk_i);
        chk("full_count", 32'(q_count_o), 4);
        chk("full_ready", 32'(br_ready_o), 0);
        chk("stall_quiet", outs_or(), 0);
        chk("full_ovf0", 32'(overflow_o), 0);
        drv(0, mk(1, 1, 0, 0, 0, 32'hDEAD, 32'hBEEF));
        step(); clr();
        @(negedge clk_i);
        chk("ovf_set", 32'(overflow_o), 1);
        chk("ovf_count", 32'(q_count_o), 4);
        stall_i = 1'b0;
        wait_drain("full_drain");
        step();
        @(negedge clk_i);
        chk("full_ready_back", 32'(br_ready_o), 1);
        chk("full_mp", 32'(mispred_cnt_o), 3);
        chk("ovf_sticky", 32'(overflow_o), 1);

        // Wrap with simultaneous push/pop, alternating ports
        for (int i = 0; i < 10; i++) begin
            e = mk(i[0], ~i[0], 0, 0, 0,
                   32'h1000 + 32'(i * 4), 32'h2000 + 32'(i));
            clr();
            drv(i % 2, e); exp_q.push_back(e);
            step();
            @(negedge clk_i);
            chk("wrap_count", 32'(q_count_o), 1);
        end
        clr();
        wait_drain("wrap_drain");
        step();
        @(negedge clk_i);
        chk("wrap_mp", 32'(mispred_cnt_o), 8);
        chk("wrap_empty", 32'(q_count_o), 0);

        // Flush with 3 queued entries and a concurrent push
        stall_i = 1'b1;
        drv(0, mk(1, 1, 0, 0, 0, 32'h30, 32'h70));
        drv(1, mk(1, 0, 0, 0, 0, 32'h34, 32'h74));
        step(); clr();
        drv(0, mk(1, 1, 0, 0, 0, 32'h38, 32'h78));
        step(); clr();
        @(negedge clk_i);
        chk("flush_pre", 32'(q_count_o), 3);
        stall_i = 1'b0;
        flush_i = 1'b1;
        drv(0, mk(1, 1, 1, 0, 0, 32'h3C, 32'h7C));
        #1;
        chk("flush_quiet", outs_or(), 0);
        step();
        flush_i = 1'b0;
        clr();
        @(negedge clk_i);
        chk("flush_count", 32'(q_count_o), 0);
        chk("flush_outs", outs_or(), 0);
        repeat (3) step();
        @(negedge clk_i);
        chk("flush_mp", 32'(mispred_cnt_o), 8);

        // Saturate the mispredict counter
        for (int i = 0; i < 65536; i++) begin
            e = mk(1, i[0], 0, 0, 0, 32'(i), ~32'(i));
            drv(0, e); exp_q.push_back(e);
            step();
        end
        clr();
        wait_drain("sat_drain");
        step();
        @(negedge clk_i);
        chk("sat_mp", 32'(mispred_cnt_o), 32'hFFFF);

        // Reset asserted mid-drain
        drv(0, mk(1, 1, 0, 0, 0, 32'h40, 32'h80));
        drv(1, mk(0, 0, 0, 1, 0, 32'h44, 32'h84));
        step(); clr();
        #2;
        rstn_i = 1'b0;
        #1;
        exp_q.delete();
        chk("rst_mid_outs", outs_or(), 0);
        chk("rst_mid_count", 32'(q_count_o), 0);
        chk("rst_mid_ready", 32'(br_ready_o), 1);
        chk("rst_mid_mp", 32'(mispred_cnt_o), 0);
        chk("rst_mid_ovf", 32'(overflow_o), 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        e = mk(1, 0, 0, 0, 1, 32'h48, 32'h88);
        drv(0, e); exp_q.push_back(e);
        step(); clr();
        wait_drain("post_rst_drain");
        step();
        @(negedge clk_i);
        chk("post_rst_count", 32'(q_count_o), 0);
        chk("post_rst_mp", 32'(mispred_cnt_o), 1);
        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
